// File: rtl/vga_timing_pkg.sv
// Mode constants and monitor state shared by the VGA display and receive paths.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } mon_state_e;

    // 640x480@60 with a 25 MHz pixel clock
    localparam int unsigned VGA_H_TOTAL = 800;
    localparam int unsigned VGA_H_SYNC  = 96;
    localparam int unsigned VGA_V_TOTAL = 525;
    localparam int unsigned VGA_V_SYNC  = 2;

    function automatic logic within_tol(input int unsigned val,
                                        input int unsigned target,
                                        input int unsigned tol);
        return ((val + tol) >= target) && (val <= (target + tol));
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous sync pin, normalised to 1 = asserted,
// followed by a registered leading/trailing edge detector (3 clk pin-to-pulse).
module sync_edge_detect #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sync_i,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, sync_q, level_q, rise_q, fall_q;
    logic asserted;

    assign asserted = sync_q ^ ACTIVE_LOW;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q  <= ACTIVE_LOW;
            sync_q  <= ACTIVE_LOW;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            meta_q  <= sync_i;
            sync_q  <= meta_q;
            level_q <= asserted;
            rise_q  <= asserted & ~level_q;
            fall_q  <= ~asserted & level_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing checker: measures line/frame geometry from hsync/vsync,
// declares lock after consecutive clean frames and regenerates pixel position.
module vga_timing_monitor
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL         = VGA_H_TOTAL,
    parameter int unsigned H_SYNC          = VGA_H_SYNC,
    parameter int unsigned H_TOL           = 2,
    parameter int unsigned V_TOTAL         = VGA_V_TOTAL,
    parameter int unsigned V_SYNC          = VGA_V_SYNC,
    parameter int unsigned LOCK_FRAMES     = 2,
    parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic        locked,
    output logic        timing_err,
    output logic        frame_start,
    output logic [11:0] line_len,
    output logic [10:0] frame_lines,
    output logic [11:0] h_pos,
    output logic [10:0] v_pos
);

    localparam int unsigned   GW       = $clog2(LOCK_FRAMES + 1);
    localparam logic [11:0]   TIMEOUT  = 12'(2 * H_TOTAL);
    localparam logic [GW-1:0] LAST_CNT = GW'(LOCK_FRAMES - 1);

    logic h_rise, h_fall, v_rise, v_fall;

    sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_hsync (
        .clk_i(clk), .rst_ni(rst), .sync_i(hsync_in), .rise_o(h_rise), .fall_o(h_fall)
    );

    sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_vsync (
        .clk_i(clk), .rst_ni(rst), .sync_i(vsync_in), .rise_o(v_rise), .fall_o(v_fall)
    );

    logic [11:0] h_pos_q, h_pos_d, line_len_q, line_len_d, hs_width_q, hs_width_d;
    logic [10:0] v_pos_q, v_pos_d, frame_lines_q, frame_lines_d;
    logic [10:0] vs_cnt_q, vs_cnt_d, vs_width_q, vs_width_d;
    logic        v_lvl_q, v_lvl_d, line_armed_q, line_armed_d, frame_bad_q, frame_bad_d;
    logic        locked_q, timing_err_q;
    logic [GW-1:0] good_cnt_q;
    mon_state_e  state_q;

    logic [11:0] h_len;
    logic [10:0] v_inc, vs_inc, lines_seen;
    logic        line_ok, line_bad, timeout, frame_ok, lose_lock, search_enter;

    assign h_len      = (h_pos_q == '1) ? h_pos_q : h_pos_q + 12'd1;
    assign v_inc      = (v_pos_q == '1) ? v_pos_q : v_pos_q + 11'd1;
    assign vs_inc     = (vs_cnt_q == '1) ? vs_cnt_q : vs_cnt_q + 11'd1;
    // A line edge coincident with the frame edge still belongs to the ending frame
    assign lines_seen = h_rise ? v_inc : v_pos_q;

    assign line_ok  = within_tol(32'(h_len), H_TOTAL, H_TOL) &&
                      within_tol(32'(hs_width_q), H_SYNC, H_TOL);
    assign line_bad = h_rise && line_armed_q && !line_ok;
    assign timeout  = (h_pos_q == TIMEOUT);
    assign frame_ok = !(frame_bad_q || line_bad) &&
                      (lines_seen == 11'(V_TOTAL)) && (vs_width_q == 11'(V_SYNC));

    assign lose_lock    = (state_q == LOCKED) && (line_bad || (v_rise && !frame_ok));
    assign search_enter = timeout || lose_lock;

    always_comb begin
        h_pos_d       = h_rise ? '0 : h_len;
        line_len_d    = h_rise ? h_len : line_len_q;
        hs_width_d    = h_fall ? h_len : hs_width_q;
        v_pos_d       = v_rise ? '0 : (h_rise ? v_inc : v_pos_q);
        frame_lines_d = v_rise ? lines_seen : frame_lines_q;
        v_lvl_d       = v_rise ? 1'b1 : (v_fall ? 1'b0 : v_lvl_q);
        vs_width_d    = v_fall ? vs_cnt_q : vs_width_q;

        vs_cnt_d = vs_cnt_q;
        if (v_rise)
            vs_cnt_d = {10'd0, h_rise};
        else if (v_lvl_q && !v_fall && h_rise)
            vs_cnt_d = vs_inc;

        line_armed_d = search_enter ? 1'b0 : (h_rise ? 1'b1 : line_armed_q);
        frame_bad_d  = (search_enter || v_rise) ? 1'b0 : (frame_bad_q | line_bad);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_pos_q       <= '0;
            line_len_q    <= '0;
            hs_width_q    <= '0;
            v_pos_q       <= '0;
            frame_lines_q <= '0;
            vs_cnt_q      <= '0;
            vs_width_q    <= '0;
            v_lvl_q       <= 1'b0;
            line_armed_q  <= 1'b0;
            frame_bad_q   <= 1'b0;
        end else begin
            h_pos_q       <= h_pos_d;
            line_len_q    <= line_len_d;
            hs_width_q    <= hs_width_d;
            v_pos_q       <= v_pos_d;
            frame_lines_q <= frame_lines_d;
            vs_cnt_q      <= vs_cnt_d;
            vs_width_q    <= vs_width_d;
            v_lvl_q       <= v_lvl_d;
            line_armed_q  <= line_armed_d;
            frame_bad_q   <= frame_bad_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= SEARCH;
            good_cnt_q   <= '0;
            locked_q     <= 1'b0;
            timing_err_q <= 1'b0;
        end else begin
            timing_err_q <= 1'b0;
            case (state_q)
                SEARCH: begin
                    locked_q <= 1'b0;
                    if (v_rise && !timeout) begin
                        state_q    <= VERIFY;
                        good_cnt_q <= '0;
                    end
                end
                VERIFY: begin
                    if (timeout) begin
                        state_q <= SEARCH;
                    end else if (v_rise) begin
                        if (!frame_ok) begin
                            good_cnt_q <= '0;
                        end else if (good_cnt_q == LAST_CNT) begin
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                        end else begin
                            good_cnt_q <= good_cnt_q + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (search_enter) begin
                        state_q      <= SEARCH;
                        locked_q     <= 1'b0;
                        timing_err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= SEARCH;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign locked      = locked_q;
    assign timing_err  = timing_err_q;
    assign frame_start = v_rise;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign h_pos       = h_pos_q;
    assign v_pos       = v_pos_q;

endmodule
